// File: rtl/multi_channel_deserializer.sv
// Multi-lane serial-to-parallel deserializer with frame-pattern word alignment by bit slipping.
// Optional lock-loss counter on o_err_cnt when DESER_ERRCNT_EN is defined (otherwise tied to zero).
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_HUNT    | searching; every mismatching frame word slips alignment by one bit
// ST_CONFIRM | frame matched, counting consecutive matches up to LOCK_COUNT
// ST_LOCKED  | aligned; matching frame words release lane words on o_q
module multi_channel_deserializer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    NUM_CH        = 2,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
  parameter int                    LOCK_COUNT    = 4,
  localparam int                   SW            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_din_en,
  input  logic [NUM_CH-1:0]            i_d,
  input  logic                         i_frame,
  input  logic                         i_align_req,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_q,
  output logic                         o_q_valid,
  output logic                         o_locked,
  output logic [SW-1:0]                o_slip_cnt,
  output logic [15:0]                  o_err_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [DATA_WIDTH-2:0]          r_sr [NUM_CH];
  logic [DATA_WIDTH-2:0]          r_fsr;
  logic [SW-1:0]                  r_bit_cnt;
  logic [SW-1:0]                  r_slip_cnt;
  logic                           r_slip_pend;
  logic [3:0]                     r_match_cnt;
  logic [3:0]                     w_match_nxt;
  logic [3:0]                     w_match_inc;
  logic [NUM_CH*DATA_WIDTH-1:0]   r_q;
  logic                           r_q_valid;
  logic                           r_locked;
  logic [NUM_CH*DATA_WIDTH-1:0]   w_word;
  logic [DATA_WIDTH-1:0]          w_fword;
  logic                           w_bound;
  logic                           w_match;
  logic                           w_slip;
  logic                           w_load;

  // Only DATA_WIDTH-1 history bits are kept; the word completes with the bit arriving now.
  assign w_bound     = i_din_en && (r_bit_cnt == SW'(DATA_WIDTH - 1));
  assign w_fword     = {r_fsr, i_frame};
  assign w_match     = (w_fword == FRAME_PATTERN);
  assign w_match_inc = r_match_cnt + 4'd1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign w_word[g*DATA_WIDTH +: DATA_WIDTH] = {r_sr[g], i_d[g]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_HUNT;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_slip      = 1'b0;
    w_load      = 1'b0;
    if (i_align_req) begin
      w_state_nxt = ST_HUNT;
      w_match_nxt = '0;
    end else if (w_bound) begin
      case (r_state)
        ST_HUNT: begin
          if (w_match) begin
            w_match_nxt = 4'd1;
            w_state_nxt = (LOCK_COUNT == 1) ? ST_LOCKED : ST_CONFIRM;
          end else begin
            w_slip = 1'b1;
          end
        end
        ST_CONFIRM: begin
          if (w_match) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == 4'(LOCK_COUNT)) w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_HUNT;
            w_match_nxt = '0;
            w_slip      = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_match) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_HUNT;
            w_match_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_CH; i++) r_sr[i] <= '0;
      r_fsr       <= '0;
      r_bit_cnt   <= '0;
      r_slip_cnt  <= '0;
      r_slip_pend <= 1'b0;
      r_q         <= '0;
      r_q_valid   <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_q_valid <= w_load;
      r_locked  <= (w_state_nxt == ST_LOCKED);
      if (w_load) r_q <= w_word;
      if (i_din_en) begin
        for (int i = 0; i < NUM_CH; i++) r_sr[i] <= w_word[i*DATA_WIDTH +: DATA_WIDTH-1];
        r_fsr       <= w_fword[DATA_WIDTH-2:0];
        // A slip stretches the next word by one bit: the count holds on the first bit after it.
        r_slip_pend <= w_slip;
        if (w_bound)
          r_bit_cnt <= '0;
        else if (!r_slip_pend)
          r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_slip)
          r_slip_cnt <= (r_slip_cnt == SW'(DATA_WIDTH - 1)) ? '0 : r_slip_cnt + 1'b1;
      end
    end
  end

`ifdef DESER_ERRCNT_EN
  logic        w_err;
  logic [15:0] r_err_cnt;

  assign w_err = w_bound && !i_align_req && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_err_cnt <= '0;
    else if (w_err && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = 16'h0;
`endif

  assign o_q        = r_q;
  assign o_q_valid  = r_q_valid;
  assign o_locked   = r_locked;
  assign o_slip_cnt = r_slip_cnt;

endmodule

// File: tb/tb_multi_channel_deserializer.sv
// Bench for multi_channel_deserializer: scenario tasks checked against a bit-history reference model.
module tb_multi_channel_deserializer;
  localparam int DW = 8;
  localparam int NCH = 2;
  localparam int LC = 4;
  localparam logic [7:0] FP = 8'hF0;
`ifdef DESER_ERRCNT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              din_en = 1'b0;
  logic [NCH-1:0]    d = '0;
  logic              frame = 1'b0;
  logic              align_req = 1'b0;
  logic [NCH*DW-1:0] q;
  logic              q_valid;
  logic              locked;
  logic [2:0]        slip_cnt;
  logic [15:0]       err_cnt;

  multi_channel_deserializer #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .FRAME_PATTERN(FP), .LOCK_COUNT(LC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_din_en(din_en), .i_d(d), .i_frame(frame),
    .i_align_req(align_req), .o_q(q), .o_q_valid(q_valid), .o_locked(locked),
    .o_slip_cnt(slip_cnt), .o_err_cnt(err_cnt)
  );

  int total = 0;
  int bad = 0;

  // reference model: history of received bits and the bit index where the next word ends
  logic [NCH:0]      hist[$];
  int                m_nbits, m_next_b, m_good, m_slip, m_err;
  logic [NCH*DW-1:0] m_q;
  logic              m_qv;
  logic              m_locked;

  // stimulus stream state
  int         fpos = 0;
  logic [7:0] fw = FP;
  logic [7:0] lw [NCH];
  bit         fixed_data = 0, rand_frames = 0, glitch_next = 0;

  task automatic model_reset();
    hist.delete();
    m_nbits = 0; m_next_b = DW - 1; m_good = 0; m_slip = 0; m_err = 0;
    m_q = '0; m_qv = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [NCH-1:0] dv, input logic fr, input bit areq);
    logic [7:0]        fword;
    logic [NCH*DW-1:0] dword;
    bit                bnd;
    bnd = 0;
    m_qv = 1'b0;
    if (en) begin
      hist.push_back({fr, dv});
      if (hist.size() > DW) void'(hist.pop_front());
      bnd = (m_nbits == m_next_b);
      m_nbits++;
    end
    if (bnd && !areq) begin
      for (int k = 0; k < DW; k++) begin
        fword[DW-1-k] = hist[k][NCH];
        for (int i = 0; i < NCH; i++) dword[i*DW + DW-1-k] = hist[k][i];
      end
      if (m_good >= LC) begin
        if (fword == FP) begin
          m_q = dword; m_qv = 1'b1;
        end else begin
          m_good = 0;
`ifdef DESER_ERRCNT_EN
          if (m_err < 65535) m_err++;
`endif
        end
        m_next_b += DW;
      end else if (fword == FP) begin
        m_good++;
        m_next_b += DW;
      end else begin
        m_good = 0;
        m_slip = (m_slip + 1) % DW;
        m_next_b += DW + 1;
      end
    end else begin
      if (bnd) m_next_b += DW;
      if (areq) m_good = 0;
    end
    m_locked = (m_good >= LC);
  endtask

  task automatic cyc(input bit en, input bit r, input bit areq, input logic [NCH-1:0] dv, input logic fr);
    @(negedge clk);
    din_en = en; rst = r; align_req = areq; d = dv; frame = fr;
    @(posedge clk);
    if (r) model_reset();
    else model_step(en, dv, fr, areq);
    #1;
  endtask

  task automatic send(input bit en, input bit areq);
    logic [NCH-1:0] dv;
    if (!en) begin
      cyc(1'b0, 1'b0, areq, NCH'($urandom), 1'($urandom));
    end else begin
      if (fpos == 0) begin
        fw = FP;
        if (glitch_next) begin
          fw = 8'hF1; glitch_next = 0;
        end else if (rand_frames && $urandom_range(0, 7) == 0) begin
          fw = 8'($urandom);
        end
        if (fixed_data) begin
          lw[0] = 8'hA5; lw[1] = 8'h3C;
        end else begin
          for (int i = 0; i < NCH; i++) lw[i] = 8'($urandom);
        end
      end
      for (int i = 0; i < NCH; i++) dv[i] = lw[i][DW-1-fpos];
      cyc(1'b1, 1'b0, areq, dv, fw[DW-1-fpos]);
      fpos = (fpos + 1) % DW;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'($urandom), NCH'($urandom), 1'($urandom));
    fpos = 0;
    total++; if (q !== 16'h0)       begin bad++; $display("FAIL reset_q got=%h exp=0000", q); end
    total++; if (q_valid !== 1'b0)  begin bad++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (slip_cnt !== 3'd0) begin bad++; $display("FAIL reset_slip got=%0d exp=0", slip_cnt); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_align();
    int c, lock_at;
    c = 0; lock_at = -1;
    fixed_data = 0; rand_frames = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, NCH'($urandom), 1'($urandom));
      c++;
      total++;
      if ({q_valid, locked, slip_cnt} !== {m_qv, m_locked, 3'(m_slip)}) begin
        bad++; $display("FAIL align_junk c=%0d got v=%b l=%b s=%0d exp v=%b l=%b s=%0d", c, q_valid, locked, slip_cnt, m_qv, m_locked, m_slip);
      end
    end
    while (c < 200 && lock_at < 0) begin
      send(1'b1, 1'b0);
      c++;
      total++;
      if ({q, q_valid, locked, slip_cnt, err_cnt} !== {m_q, m_qv, m_locked, 3'(m_slip), 16'(m_err)}) begin
        bad++; $display("FAIL align_model c=%0d got q=%h v=%b l=%b s=%0d exp q=%h v=%b l=%b s=%0d", c, q, q_valid, locked, slip_cnt, m_q, m_qv, m_locked, m_slip);
      end
      if (locked === 1'b1) lock_at = c;
    end
    total++; if (lock_at != 59)     begin bad++; $display("FAIL align_lock_cycle got=%0d exp=59", lock_at); end
    total++; if (slip_cnt !== 3'd3) begin bad++; $display("FAIL align_slip got=%0d exp=3", slip_cnt); end
  endtask

  task automatic test_data();
    int nv, last, first;
    nv = 0; last = -1; first = -1;
    fixed_data = 1;
    for (int i = 0; i < 48; i++) begin
      send(1'b1, 1'b0);
      total++;
      if ({q, q_valid, locked, slip_cnt} !== {m_q, m_qv, m_locked, 3'(m_slip)}) begin
        bad++; $display("FAIL data_model i=%0d got q=%h v=%b l=%b exp q=%h v=%b l=%b", i, q, q_valid, locked, m_q, m_qv, m_locked);
      end
      if (q_valid === 1'b1) begin
        nv++;
        total++; if (q !== 16'h3CA5) begin bad++; $display("FAIL data_word got=%h exp=3ca5", q); end
        if (last < 0) first = i;
        else begin
          total++; if (i - last != 8) begin bad++; $display("FAIL data_interval got=%0d exp=8", i - last); end
        end
        last = i;
      end
    end
    total++; if (first != 7) begin bad++; $display("FAIL data_first_strobe got=%0d exp=7", first); end
    total++; if (nv != 6)    begin bad++; $display("FAIL data_strobes got=%0d exp=6", nv); end
  endtask

  task automatic test_glitch();
    int nv, lock_at;
    nv = 0; lock_at = -1;
    glitch_next = 1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0);
      if (q_valid === 1'b1) nv++;
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL glitch_unlock got=%b exp=0", locked); end
    total++; if (nv != 0)         begin bad++; $display("FAIL glitch_no_strobe got=%0d exp=0", nv); end
    total++; if (err_cnt !== 16'(EXP_ERR)) begin bad++; $display("FAIL glitch_err got=%0d exp=%0d", err_cnt, EXP_ERR); end
    for (int i = 0; i < 32; i++) begin
      send(1'b1, 1'b0);
      total++;
      if ({q, q_valid, locked, slip_cnt, err_cnt} !== {m_q, m_qv, m_locked, 3'(m_slip), 16'(m_err)}) begin
        bad++; $display("FAIL glitch_model i=%0d got v=%b l=%b e=%0d exp v=%b l=%b e=%0d", i, q_valid, locked, err_cnt, m_qv, m_locked, m_err);
      end
      if (locked === 1'b1 && lock_at < 0) lock_at = i;
    end
    total++; if (lock_at != 31)     begin bad++; $display("FAIL glitch_relock got=%0d exp=31", lock_at); end
    total++; if (slip_cnt !== 3'd3) begin bad++; $display("FAIL glitch_slip got=%0d exp=3", slip_cnt); end
  endtask

  task automatic test_gapped();
    int nv, last;
    nv = 0; last = -1;
    fixed_data = 1;
    for (int i = 0; i < 96; i++) begin
      send(1'(i % 2), 1'b0);
      total++;
      if ({q, q_valid, locked} !== {m_q, m_qv, m_locked}) begin
        bad++; $display("FAIL gap_model i=%0d got q=%h v=%b l=%b exp q=%h v=%b l=%b", i, q, q_valid, locked, m_q, m_qv, m_locked);
      end
      if (q_valid === 1'b1) begin
        nv++;
        total++; if (q !== 16'h3CA5) begin bad++; $display("FAIL gap_word got=%h exp=3ca5", q); end
        total++;
        if ((last < 0 && i != 15) || (last >= 0 && i - last != 16)) begin
          bad++; $display("FAIL gap_interval at=%0d prev=%0d exp_step=16", i, last);
        end
        last = i;
      end
    end
    total++; if (nv != 6) begin bad++; $display("FAIL gap_strobes got=%0d exp=6", nv); end
  endtask

  task automatic test_ctrl();
    int lock_at;
    lock_at = -1;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL areq_unlock got=%b exp=0", locked); end
    for (int i = 0; i < 28; i++) begin
      send(1'b1, 1'b0);
      if (locked === 1'b1 && lock_at < 0) lock_at = i;
    end
    total++; if (lock_at != 27)     begin bad++; $display("FAIL areq_relock got=%0d exp=27", lock_at); end
    total++; if (slip_cnt !== 3'd3) begin bad++; $display("FAIL areq_slip got=%0d exp=3", slip_cnt); end
    total++; if (err_cnt !== 16'(EXP_ERR)) begin bad++; $display("FAIL areq_err got=%0d exp=%0d", err_cnt, EXP_ERR); end
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, NCH'($urandom), 1'($urandom));
    total++;
    if ({q, q_valid, locked, slip_cnt, err_cnt} !== {16'h0, 1'b0, 1'b0, 3'd0, 16'd0}) begin
      bad++; $display("FAIL midrst got q=%h v=%b l=%b s=%0d e=%0d exp all zero", q, q_valid, locked, slip_cnt, err_cnt);
    end
  endtask

  task automatic test_random();
    fixed_data = 0; rand_frames = 1;
    for (int i = 0; i < 1500; i++) begin
      send($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      total++;
      if ({q, q_valid, locked, slip_cnt, err_cnt} !== {m_q, m_qv, m_locked, 3'(m_slip), 16'(m_err)}) begin
        bad++; $display("FAIL rand_model i=%0d got q=%h v=%b l=%b s=%0d e=%0d exp q=%h v=%b l=%b s=%0d e=%0d", i, q, q_valid, locked, slip_cnt, err_cnt, m_q, m_qv, m_locked, m_slip, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_align();
    test_data();
    test_glitch();
    test_gapped();
    test_ctrl();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
